// File: rtl/rtsnoc_pkg.sv
// Shared geometry helpers and TX state encoding for the RTSNoC <-> RMI channel bridge.
package rtsnoc_pkg;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int bus_size(input int size_x, input int size_y, input int size_data);
    return size_data + 2 * size_x + 2 * size_y + 6;
  endfunction

  function automatic int addr_w(input int size_x, input int size_y);
    return size_x + size_y + 3;
  endfunction

  // Payload bits left in a flit after the channel id and last marker.
  function automatic int pl_w(input int size_data, input int n_ch);
    return size_data - ch_w(n_ch) - 1;
  endfunction

  function automatic int nflits(input int msg_size, input int pl);
    return (msg_size + pl - 1) / pl;
  endfunction

  function automatic int cnt_w(input int n_flits);
    return (n_flits > 1) ? $clog2(n_flits) : 1;
  endfunction

endpackage

// File: rtl/rtsnoc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last granted requester.
module rtsnoc_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] gidx;
  int            idx;

  always_comb begin
    gnt  = '0;
    gidx = ptr_q;
    idx  = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
        gidx     = IW'(idx);
      end
    end
  end

  // Reset pointer at N-1 so channel 0 has first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IW'(N - 1);
    end else if (en && |req) begin
      ptr_q <= gidx;
    end
  end

endmodule

// File: rtl/rtsnoc_rmi_bridge.sv
// Bridges one RTSNoC router port to N_CH ac_channel rx/tx pairs, splitting RMI messages into
// channel-tagged flits on transmit and reassembling them per channel on receive.
module rtsnoc_rmi_bridge
  import rtsnoc_pkg::*;
#(
  parameter int SIZE_X       = 1,
  parameter int SIZE_Y       = 1,
  parameter int SIZE_DATA    = 56,
  parameter int RMI_MSG_SIZE = 80,
  parameter int N_CH         = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  output logic [SIZE_DATA+2*SIZE_X+2*SIZE_Y+5:0] din_o,
  output logic                                 wr_o,
  input  logic                                 wait_i,
  input  logic [SIZE_DATA+2*SIZE_X+2*SIZE_Y+5:0] dout_i,
  input  logic                                 nd_i,
  output logic                                 rd_o,
  input  logic [SIZE_X-1:0]                    x,
  input  logic [SIZE_Y-1:0]                    y,
  input  logic [2:0]                           local_addr,
  input  logic [N_CH*(SIZE_X+SIZE_Y+3)-1:0]    tx_dst_i,
  output logic [N_CH*RMI_MSG_SIZE-1:0]         rx_ch_z_o,
  output logic [N_CH-1:0]                      rx_ch_vz_o,
  input  logic [N_CH-1:0]                      rx_ch_lz_i,
  input  logic [N_CH*RMI_MSG_SIZE-1:0]         tx_ch_z_i,
  output logic [N_CH-1:0]                      tx_ch_vz_o,
  input  logic [N_CH-1:0]                      tx_ch_lz_i
);
  localparam int CH_W   = ch_w(N_CH);
  localparam int PL     = pl_w(SIZE_DATA, N_CH);
  localparam int NFLITS = nflits(RMI_MSG_SIZE, PL);
  localparam int CNT_W  = cnt_w(NFLITS);
  localparam int ADDR_W = addr_w(SIZE_X, SIZE_Y);
  localparam int AW     = NFLITS * PL;

  // ---------------- TX path ----------------
  tx_state_e               state_q, state_d;
  logic [RMI_MSG_SIZE-1:0] hold_q [N_CH];
  logic [ADDR_W-1:0]       dst_arr [N_CH];
  logic [N_CH-1:0]         full_q;
  logic [N_CH-1:0]         gnt;
  logic [CH_W-1:0]         sel_q, gnt_idx;
  logic [CNT_W-1:0]        k_q;
  logic                    arb_en, accept, tx_last;
  logic [AW-1:0]           tx_pad;

  for (genvar c = 0; c < N_CH; c++) begin : g_dst
    assign dst_arr[c] = tx_dst_i[c*ADDR_W +: ADDR_W];
  end

  assign arb_en     = (state_q == TX_IDLE) && |full_q;
  assign tx_ch_vz_o = ~full_q;

  rtsnoc_rr_arbiter #(.N(N_CH)) u_arb (
    .clk (clk_i),
    .rst (rst_i),
    .en  (arb_en),
    .req (full_q),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (gnt[c]) gnt_idx = CH_W'(c);
    end
  end

  always_comb begin
    state_d = state_q;
    wr_o    = 1'b0;
    din_o   = '0;
    accept  = 1'b0;
    tx_pad  = '0;
    tx_pad[RMI_MSG_SIZE-1:0] = hold_q[sel_q];
    tx_last = (k_q == CNT_W'(NFLITS - 1));
    case (state_q)
      TX_IDLE: begin
        if (arb_en) state_d = TX_SEND;
      end
      TX_SEND: begin
        wr_o   = 1'b1;
        din_o  = {x, y, local_addr, dst_arr[sel_q], sel_q, tx_last, tx_pad[k_q*PL +: PL]};
        accept = !wait_i;
        if (accept && tx_last) state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      sel_q   <= '0;
      k_q     <= '0;
      full_q  <= '0;
      for (int c = 0; c < N_CH; c++) hold_q[c] <= '0;
    end else begin
      state_q <= state_d;
      if (arb_en) begin
        sel_q <= gnt_idx;
        k_q   <= '0;
      end else if (accept) begin
        k_q <= tx_last ? '0 : k_q + 1'b1;
      end
      // The granted channel stays full until its last flit leaves, so it cannot be overwritten.
      for (int c = 0; c < N_CH; c++) begin
        if (tx_ch_lz_i[c] && !full_q[c]) begin
          full_q[c] <= 1'b1;
          hold_q[c] <= tx_ch_z_i[c*RMI_MSG_SIZE +: RMI_MSG_SIZE];
        end else if (accept && tx_last && sel_q == CH_W'(c)) begin
          full_q[c] <= 1'b0;
        end
      end
    end
  end

  // ---------------- RX path ----------------
  logic [AW-1:0]           asm_q [N_CH];
  logic [AW-1:0]           asm_d [N_CH];
  logic [CNT_W-1:0]        cnt_q [N_CH];
  logic [RMI_MSG_SIZE-1:0] out_q [N_CH];
  logic [N_CH-1:0]         vz_q, hit;
  logic [CH_W-1:0]         rx_ch;
  logic                    rx_last, sink_ready;
  logic [PL-1:0]           rx_pl;

  assign rx_ch   = dout_i[SIZE_DATA-1 -: CH_W];
  assign rx_last = dout_i[PL];
  assign rx_pl   = dout_i[PL-1:0];

  // A last flit waits only while its channel output is still unread; a same-cycle read frees it.
  always_comb begin
    sink_ready = 1'b1;
    hit        = '0;
    for (int c = 0; c < N_CH; c++) begin
      hit[c] = (rx_ch == CH_W'(c));
      if (hit[c] && rx_last && vz_q[c] && !rx_ch_lz_i[c]) sink_ready = 1'b0;
    end
    rd_o = nd_i && sink_ready;
    for (int c = 0; c < N_CH; c++) begin
      asm_d[c] = asm_q[c];
      if (rd_o && hit[c]) asm_d[c][cnt_q[c]*PL +: PL] = rx_pl;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vz_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        asm_q[c] <= '0;
        cnt_q[c] <= '0;
        out_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        asm_q[c] <= asm_d[c];
        if (rx_ch_lz_i[c] && vz_q[c]) vz_q[c] <= 1'b0;
        if (rd_o && hit[c]) begin
          if (rx_last) begin
            out_q[c] <= asm_d[c][RMI_MSG_SIZE-1:0];
            vz_q[c]  <= 1'b1;
            cnt_q[c] <= '0;
          end else if (cnt_q[c] != CNT_W'(NFLITS - 1)) begin
            cnt_q[c] <= cnt_q[c] + 1'b1;
          end
        end
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_rx_out
    assign rx_ch_z_o[c*RMI_MSG_SIZE +: RMI_MSG_SIZE] = out_q[c];
  end
  assign rx_ch_vz_o = vz_q;

endmodule
